adder_arbiter: RTL
==================

# adder_arbiter

Round-robin arbiter that shares one 8-bit carry-lookahead `adder` instance among `NREQ` requesters. It sits in the gamma coder between the operand-producing stages and the single adder datapath. It accepts one operand pair per cycle through valid/ready handshakes and returns a registered 9-bit sum tagged with the requester index. Throughput is one addition per clock, with single-cycle latency through a one-entry output stage.

## Interface
- `NREQ`, default 4: number of requesters; legal values are 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the requester index.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NREQ  per-requester operand-pair valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high per cycle.
- `req_a`  in  8*NREQ  operand A; requester i owns bits [8i+7:8i].
- `req_b`  in  8*NREQ  operand B; same packing as `req_a`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  downstream accepts the result.
- `rsp_sum`  out  9  registered A+B; bit 8 is the carry out (adder `q8`).
- `rsp_id`  out  IDW  index of the requester that owns `rsp_sum`.

## Operation
- **Adder binding.** Exactly one `adder` instance is used, with carry-in fixed at 0. The granted requester's `req_a`/`req_b` drive `a0..a7`/`b0..b7` through a mux. Outputs `q0..q8` form the 9-bit sum.
- **Slot free.** `slot_free = !rsp_valid || rsp_ready`.
- **Arbitration.** This is combinational. Among the requesters with `req_valid`=1, the first one found scanning upward from pointer `ptr` (wrapping modulo NREQ) is selected. `req_ready[sel]` = `slot_free`; all other `req_ready` bits are 0.
  - `req_ready` may depend on `req_valid` and `rsp_ready`.
  - No `req_ready` bit is high when no request is pending.
- **Accept.** An accept occurs on a cycle where `req_valid[i] && req_ready[i]`. On the next edge:
  - `rsp_sum` ← A_i + B_i (0..510).
  - `rsp_id` ← i.
  - `rsp_valid` ← 1.
  - `ptr` ← (i+1) mod NREQ.
- **Drain without refill.** If `rsp_valid && rsp_ready` and there is no accept, then `rsp_valid` ← 0. `rsp_sum` and `rsp_id` hold their last values.
- **Drain and refill in the same cycle.** The old result is consumed and the new result is loaded; `rsp_valid` stays 1. This gives back-to-back throughput.
- **Stall.** While `rsp_valid && !rsp_ready`, `rsp_sum`, `rsp_id` and `rsp_valid` hold, all `req_ready` bits are 0, and `ptr` holds.
- **Pointer.** `ptr` moves only on an accept. With no accept it holds, so a requester that is passed over stays next in line.
- **Requester rule.** Once a requester raises `req_valid`, it holds the signal and its operands stable until accepted. Each requester waits at most NREQ-1 grants (starvation bound).
- **Width.** The sum is exact and never truncated. 0xFF+0xFF = 0x1FE.

## Timing
- **Reset values.** While `rst`=1 (asynchronous):
  - `rsp_valid`=0, `rsp_sum`=9'h000, `rsp_id`=0, `ptr`=0.
  - `req_ready` is forced to all-zero.
- **Reset deassertion.** The first accept is possible in the first cycle with `rst`=0.
- **Latency.** A pair accepted at edge T produces `rsp_valid`=1 with its sum after edge T; the result is visible in cycle T+1.
- **Sustained rate.** One accept per cycle while `rsp_ready`=1 and any `req_valid` is high.
- **Reset mid-operation.** An in-flight result is discarded with no response, and `ptr` returns to 0. Requesters must re-present their pairs after reset.
- **Simultaneous events.** When all NREQ requesters are valid with `ptr`=k, the grant order is k, k+1, …, wrapping.
- **Combinational paths.** `req_valid` and `rsp_ready` reach `req_ready` through combinational logic only. No combinational path runs from `req_a`/`req_b` to any output.

## Test plan
- **Reset and single request.** Assert reset, release it, then present requester 2 only with A=0x12, B=0x34. Required response:
  - `req_ready`=4'b0100 in the presentation cycle.
  - Next cycle: `rsp_valid`=1, `rsp_sum`=0x046, `rsp_id`=2.
- **Carry out.** Requester 0 presents A=0xFF, B=0xFF, then A=0x80, B=0x80. Required response: `rsp_sum`=0x1FE then 0x100. Also check 0x00+0x00 → 0x000.
- **Round-robin fairness.** Hold all four requesters valid continuously with `rsp_ready`=1. Required response:
  - `rsp_id` sequence is 0, 1, 2, 3, 0, 1, …, one result per cycle with no bubbles.
  - Each accept returns the correct sum.
- **Backpressure.** Hold `rsp_ready`=0 for 5 cycles with a result pending. Required response:
  - `req_ready`=0 throughout the stall.
  - `rsp_sum` and `rsp_id` stay stable.
  - On release, the held result is consumed and the next grant occurs in the same cycle.
- **Pointer hold.** Requester 1 is granted, then no requests arrive for 3 cycles, then requesters 0 and 2 both raise `req_valid`. Required response: requester 2 is granted first.
- **Reset mid-operation.** Assert `rst` while `rsp_valid`=1 and `rsp_ready`=0. Required response:
  - `rsp_valid` drops immediately, without waiting for a clock edge.
  - After release, with all requesters valid, the first grant goes to requester 0.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing a single 8-bit carry-lookahead adder among NREQ
// requesters, with a one-entry registered result stage (sum tagged by requester id).

module adder (
   input  logic a0, a1, a2, a3, a4, a5, a6, a7,
   input  logic b0, b1, b2, b3, b4, b5, b6, b7,
   input  logic ci,
   output logic q0, q1, q2, q3, q4, q5, q6, q7, q8
);
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] p;
   logic [7:0] g;
   logic [8:0] c;
   logic       pp;

   assign a = {a7, a6, a5, a4, a3, a2, a1, a0};
   assign b = {b7, b6, b5, b4, b3, b2, b1, b0};

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_pg
         assign p[gi] = a[gi] ^ b[gi];
         assign g[gi] = a[gi] & b[gi];
      end
   endgenerate

   // Every carry is a flat sum of generate terms gated by propagate chains,
   // so no carry depends on a lower carry.
   always_comb begin
      c  = '0;
      pp = 1'b0;
      c[0] = ci;
      for (int i = 0; i < 8; i++) begin
         c[i+1] = g[i];
         pp = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            c[i+1] = c[i+1] | (pp & g[j]);
            pp = pp & p[j];
         end
         c[i+1] = c[i+1] | (pp & ci);
      end
   end

   assign {q7, q6, q5, q4, q3, q2, q1, q0} = p ^ c[7:0];
   assign q8 = c[8];
endmodule

module adder_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [8*NREQ-1:0] req_a,
   input  logic [8*NREQ-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [8:0]        rsp_sum,
   output logic [IDW-1:0]    rsp_id
);
   logic [IDW-1:0] ptr_reg;
   logic [IDW-1:0] sel;
   logic           found;
   logic           slot_free;
   logic           accept;
   logic [7:0]     a_sel;
   logic [7:0]     b_sel;
   logic [8:0]     sum;
   logic [IDW-1:0] ptr_next;
   int             idx;

   assign slot_free = !rsp_valid || rsp_ready;

   // First valid requester scanning upward from ptr_reg, wrapping at NREQ.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      for (int off = 0; off < NREQ; off++) begin
         idx = int'(ptr_reg) + off;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_valid[idx]) begin
            sel   = IDW'(idx);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (!rst && found && slot_free) req_ready[sel] = 1'b1;
   end

   assign accept = !rst && found && slot_free;

   always_comb begin
      a_sel = 8'h00;
      b_sel = 8'h00;
      for (int i = 0; i < NREQ; i++) begin
         if (sel == IDW'(i)) begin
            a_sel = req_a[8*i +: 8];
            b_sel = req_b[8*i +: 8];
         end
      end
   end

   adder u_adder (
      .a0(a_sel[0]), .a1(a_sel[1]), .a2(a_sel[2]), .a3(a_sel[3]),
      .a4(a_sel[4]), .a5(a_sel[5]), .a6(a_sel[6]), .a7(a_sel[7]),
      .b0(b_sel[0]), .b1(b_sel[1]), .b2(b_sel[2]), .b3(b_sel[3]),
      .b4(b_sel[4]), .b5(b_sel[5]), .b6(b_sel[6]), .b7(b_sel[7]),
      .ci(1'b0),
      .q0(sum[0]), .q1(sum[1]), .q2(sum[2]), .q3(sum[3]), .q4(sum[4]),
      .q5(sum[5]), .q6(sum[6]), .q7(sum[7]), .q8(sum[8])
   );

   assign ptr_next = (sel == IDW'(NREQ - 1)) ? '0 : sel + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_sum   <= 9'h000;
         rsp_id    <= '0;
         ptr_reg   <= '0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_sum   <= sum;
         rsp_id    <= sel;
         ptr_reg   <= ptr_next;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end
endmodule
